// File: rtl/flex_deserializer.sv
// Serial-to-parallel converter with early word termination and selectable bit order.
// Valid/ready backpressure on the serial input and on the parallel output.
module flex_deserializer #(
  parameter int DATA_BUS_WIDTH = 16,
  parameter bit MSB_FIRST      = 1'b1,
  parameter int LEN_WIDTH      = $clog2(DATA_BUS_WIDTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic                      data_i,
  input  logic                      data_val_i,
  input  logic                      data_last_i,
  output logic                      data_ready_o,
  output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
  output logic [LEN_WIDTH-1:0]      deser_len_o,
  output logic                      deser_data_val_o,
  input  logic                      deser_data_ready_i
);

  localparam int W     = DATA_BUS_WIDTH;
  localparam int CNT_W = $clog2(W);

  typedef enum logic {COLLECT, PENDING} state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [W-1:0]           buf_q;
  logic [W-1:0]           data_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic                   val_q;

  logic                   out_free;
  logic                   accept;
  logic                   complete;
  logic [CNT_W-1:0]       pos;
  logic [W-1:0]           word_d;
  logic [LEN_WIDTH-1:0]   word_len;

  assign out_free     = !val_q || deser_data_ready_i;
  assign data_ready_o = !srst_i && (state_q == COLLECT);
  assign accept       = data_val_i && data_ready_o;
  assign complete     = accept && ((cnt_q == CNT_W'(W - 1)) || data_last_i);
  assign pos          = MSB_FIRST ? (CNT_W'(W - 1) - cnt_q) : cnt_q;
  // In PENDING cnt_q still holds the last index, so this is the held word's length too.
  assign word_len     = LEN_WIDTH'(cnt_q) + LEN_WIDTH'(1);

  always_comb begin
    word_d      = buf_q;
    word_d[pos] = data_i;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      val_q   <= 1'b0;
    end else begin
      // A pop clears the output; a load at the same edge overrides it below.
      if (val_q && deser_data_ready_i) begin
        val_q  <= 1'b0;
        data_q <= '0;
        len_q  <= '0;
      end
      case (state_q)
        COLLECT: begin
          if (complete) begin
            if (out_free) begin
              data_q <= word_d;
              len_q  <= word_len;
              val_q  <= 1'b1;
              buf_q  <= '0;
              cnt_q  <= '0;
            end else begin
              buf_q   <= word_d;
              state_q <= PENDING;
            end
          end else if (accept) begin
            buf_q <= word_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        PENDING: begin
          if (out_free) begin
            data_q  <= buf_q;
            len_q   <= word_len;
            val_q   <= 1'b1;
            buf_q   <= '0;
            cnt_q   <= '0;
            state_q <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign deser_data_o     = data_q;
  assign deser_len_o      = len_q;
  assign deser_data_val_o = val_q;

endmodule

// File: tb/tb_flex_deserializer.sv
// Bench for flex_deserializer: MSB-first and LSB-first instances share one stimulus
// stream and are compared every cycle against a bit-list reference model.
module tb_flex_deserializer;
  localparam int W = 16;
  localparam int L = 5;

  logic clk;
  logic srst, din, dval, dlast, rdy;
  logic         ready_m, val_m, ready_l, val_l;
  logic [W-1:0] data_m, data_l;
  logic [L-1:0] len_m, len_l;

  int n_checks = 0;
  int n_fails  = 0;

  flex_deserializer #(.DATA_BUS_WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk_i(clk), .srst_i(srst), .data_i(din), .data_val_i(dval), .data_last_i(dlast),
    .data_ready_o(ready_m), .deser_data_o(data_m), .deser_len_o(len_m),
    .deser_data_val_o(val_m), .deser_data_ready_i(rdy));

  flex_deserializer #(.DATA_BUS_WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_i(clk), .srst_i(srst), .data_i(din), .data_val_i(dval), .data_last_i(dlast),
    .data_ready_o(ready_l), .deser_data_o(data_l), .deser_len_o(len_l),
    .deser_data_val_o(val_l), .deser_data_ready_i(rdy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bits of the current word, one held word, and the output slot.
  bit           m_bits[$];
  bit           m_pend;
  logic [W-1:0] m_pend_m, m_pend_l;
  logic [L-1:0] m_pend_len;
  bit           m_val;
  logic [W-1:0] m_dm, m_dl;
  logic [L-1:0] m_len;

  function automatic logic [W-1:0] build(input bit msb);
    logic [W-1:0] w = '0;
    for (int k = 0; k < m_bits.size(); k++) begin
      if (msb) w[W-1-k] = m_bits[k];
      else     w[k]     = m_bits[k];
    end
    return w;
  endfunction

  task automatic model_edge();
    bit free;
    if (srst) begin
      m_bits.delete();
      m_pend = 0; m_val = 0; m_dm = '0; m_dl = '0; m_len = '0;
    end else begin
      free = !m_val || rdy;
      if (m_val && rdy) begin
        m_val = 0; m_dm = '0; m_dl = '0; m_len = '0;
      end
      if (m_pend) begin
        if (free) begin
          m_val = 1; m_dm = m_pend_m; m_dl = m_pend_l; m_len = m_pend_len;
          m_pend = 0;
        end
      end else if (dval) begin
        m_bits.push_back(din);
        if (m_bits.size() == W || dlast) begin
          if (free) begin
            m_val = 1; m_dm = build(1); m_dl = build(0); m_len = L'(m_bits.size());
          end else begin
            m_pend = 1; m_pend_m = build(1); m_pend_l = build(0); m_pend_len = L'(m_bits.size());
          end
          m_bits.delete();
        end
      end
    end
  endtask

  task automatic compare();
    bit exp_ready;
    exp_ready = !srst && !m_pend;
    n_checks++;
    if (ready_m !== exp_ready || val_m !== m_val || len_m !== m_len || data_m !== m_dm) begin
      n_fails++;
      $display("FAIL msb_cycle t=%0t got rdy=%b val=%b len=%0d data=%h exp rdy=%b val=%b len=%0d data=%h",
               $time, ready_m, val_m, len_m, data_m, exp_ready, m_val, m_len, m_dm);
    end
    n_checks++;
    if (ready_l !== exp_ready || val_l !== m_val || len_l !== m_len || data_l !== m_dl) begin
      n_fails++;
      $display("FAIL lsb_cycle t=%0t got rdy=%b val=%b len=%0d data=%h exp rdy=%b val=%b len=%0d data=%h",
               $time, ready_l, val_l, len_l, data_l, exp_ready, m_val, m_len, m_dl);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic step(input bit s, input bit v, input bit l, input bit d, input bit r);
    srst = s; dval = v; dlast = l; din = d; rdy = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  // Sends the first n bits of w, most significant first; last flag on the final bit.
  task automatic send_word(input logic [W-1:0] w, input int n, input bit last_at_end, input bit r);
    for (int k = 0; k < n; k++)
      step(1'b0, 1'b1, last_at_end && (k == n - 1), w[W-1-k], r);
  endtask

  initial begin
    srst = 1; din = 1; dval = 1; dlast = 0; rdy = 1;
    m_pend = 0; m_val = 0; m_dm = '0; m_dl = '0; m_len = '0;
    m_pend_m = '0; m_pend_l = '0; m_pend_len = '0;

    // Reset held while bits are offered
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("reset_ready", {31'd0, ready_m}, 32'd0);
    chk("reset_val",   {31'd0, val_m},   32'd0);
    chk("reset_data",  {16'd0, data_m},  32'd0);
    chk("reset_len",   {27'd0, len_m},   32'd0);

    // Full word, both bit orders
    send_word(16'hAC35, 16, 1'b0, 1'b1);
    chk("full_msb_data", {16'd0, data_m}, 32'h0000AC35);
    chk("full_msb_len",  {27'd0, len_m},  32'd16);
    chk("full_lsb_data", {16'd0, data_l}, 32'h0000AC35);
    chk("full_msb_val",  {31'd0, val_m},  32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("full_val_drop", {31'd0, val_m},  32'd0);

    // Early end after three bits
    send_word(16'hC000, 3, 1'b1, 1'b1);
    chk("early_msb_data", {16'd0, data_m}, 32'h0000C000);
    chk("early_lsb_data", {16'd0, data_l}, 32'h00000003);
    chk("early_len",      {27'd0, len_m},  32'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: two words while the consumer stalls
    send_word(16'h1234, 16, 1'b0, 1'b0);
    send_word(16'hBEEF, 16, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("bp_ready_low", {31'd0, ready_m}, 32'd0);
    chk("bp_hold_msb",  {16'd0, data_m},  32'h00001234);
    chk("bp_hold_lsb",  {16'd0, data_l},  32'h00002C48);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_word2_data", {16'd0, data_m},  32'h0000BEEF);
    chk("bp_word2_val",  {31'd0, val_m},   32'd1);
    chk("bp_ready_back", {31'd0, ready_m}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a word
    send_word(16'hFFFF, 7, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(16'h5A5A, 16, 1'b0, 1'b1);
    chk("midrst_data", {16'd0, data_m}, 32'h00005A5A);
    chk("midrst_len",  {27'd0, len_m},  32'd16);

    // Randomised traffic
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
